// File: rtl/wide_add_pkg.sv
// rtl/wide_add_pkg.sv - shared types and limits for the wide add sequencer
//
// Purpose: state encoding and legal-range limit shared by wide_add_sequencer.
// Ports:   none (package).
package wide_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wadd_state_t;

    localparam int WADD_MAX_BYTES = 16;

endpackage

// File: rtl/carry_select_adder_8bit.sv
// rtl/carry_select_adder_8bit.sv - 8-bit carry-select adder byte datapath
//
// Purpose: S = A + B + Cin, Cout = carry out of bit 7.
// Ports:   A, B  - 8-bit addends
//          Cin   - carry in
//          S     - 8-bit sum
//          Cout  - carry out
module carry_select_adder_8bit (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [7:0] S,
    output logic       Cout
);

    logic [4:0] lo_sum;
    logic [4:0] hi_sum0;
    logic [4:0] hi_sum1;

    // Upper nibble is computed for both possible carries and the real
    // carry out of the lower nibble picks one.
    always_comb begin
        lo_sum  = {1'b0, A[3:0]} + {1'b0, B[3:0]} + {4'b0000, Cin};
        hi_sum0 = {1'b0, A[7:4]} + {1'b0, B[7:4]};
        hi_sum1 = {1'b0, A[7:4]} + {1'b0, B[7:4]} + 5'd1;
        if (lo_sum[4]) begin
            S    = {hi_sum1[3:0], lo_sum[3:0]};
            Cout = hi_sum1[4];
        end else begin
            S    = {hi_sum0[3:0], lo_sum[3:0]};
            Cout = hi_sum0[4];
        end
    end

endmodule

// File: rtl/wide_add_sequencer.sv
// rtl/wide_add_sequencer.sv - byte-serial wide adder around one 8-bit adder
//
// Purpose: accepts a wide operand pair, adds it one byte per cycle LSB first
//          through a single carry_select_adder_8bit, and returns the wide sum.
// Ports:   clk, rst_n            - clock, asynchronous active-low reset
//          in_valid/in_ready     - operand handshake (a, b, cin)
//          out_valid/out_ready   - result handshake (sum, cout, ovf)
//          sum                   - a+b+cin modulo 2^(8*NBYTES)
//          cout                  - carry out of the top byte
//          ovf                   - two's-complement overflow of the add
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  ovf
);

    localparam int W     = 8 * NBYTES;
    localparam int CNT_W = $clog2(NBYTES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

    generate
        if (NBYTES < 2 || NBYTES > WADD_MAX_BYTES) begin : g_bad_nbytes
            $error("wide_add_sequencer: NBYTES out of legal range 2..16");
        end
    endgenerate

    wadd_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [7:0]       a_byte;
    logic [7:0]       b_byte;
    logic [7:0]       add_s;
    logic             add_cout;

    // Byte select from the registered operands.
    always_comb begin
        a_byte = 8'h00;
        b_byte = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                a_byte = a_q[8*i +: 8];
                b_byte = b_q[8*i +: 8];
            end
        end
    end

    carry_select_adder_8bit u_byte_adder (
        .A    (a_byte),
        .B    (b_byte),
        .Cin  (carry_q),
        .S    (add_s),
        .Cout (add_cout)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = a;
                    b_d        = b;
                    carry_d    = cin;
                    cnt_d      = '0;
                    ovf_d      = 1'b0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        sum_d[8*i +: 8] = add_s;
                    end
                end
                carry_d = add_cout;
                if (cnt_q == LAST_CNT) begin
                    // The top byte's S is the sum MSB, so overflow is
                    // resolved in the same cycle as the last write.
                    ovf_d       = (a_q[W-1] == b_q[W-1]) && (add_s[7] != a_q[W-1]);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = carry_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb/tb_wide_add_sequencer.sv - self-checking bench for wide_add_sequencer
module tb_wide_add_sequencer;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks;
    int errors;
    int cyc;
    int acc_cnt;
    int acc_cyc [0:7];
    logic watch_ov;
    logic saw_ov;

    wide_add_sequencer #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter and accept / stray out_valid monitor.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && in_valid && in_ready) begin
            if (acc_cnt < 8) acc_cyc[acc_cnt] <= cyc;
            acc_cnt <= acc_cnt + 1;
        end
        if (watch_ov && out_valid) saw_ov <= 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation: offer, wait for result, optionally stall, then consume.
    task automatic run_op(input logic [W-1:0] a_i, input logic [W-1:0] b_i, input logic cin_i,
                          input int hold,
                          output logic [W-1:0] s_o, output logic c_o, output logic o_o,
                          output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 0, 1);
        a = a_i; b = b_i; cin = cin_i; in_valid = 1'b1;
        step();                          // accept edge
        in_valid = 1'b0;
        a = ~a_i; b = ~b_i; cin = ~cin_i; // registered copies must be used
        lat = 1;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        if (lat >= 50) check("out_valid_timeout", 0, 1);
        s_o = sum; c_o = cout; o_o = ovf;
        for (int k = 0; k < hold; k++) begin
            in_valid = k[0];
            a = 32'h1234_5678; b = 32'h1111_1111;
            step();
            check("bp_valid", {63'b0, out_valid}, 64'd1);
            check("bp_ready", {63'b0, in_ready}, 64'd0);
            check("bp_sum", {32'b0, sum}, {32'b0, s_o});
            check("bp_co_ov", {62'b0, cout, ovf}, {62'b0, c_o, o_o});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();                          // consume edge
        out_ready = 1'b0;
    endtask

    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           lat;
    logic [W:0]   ref_full;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    int           n;

    initial begin
        checks = 0; errors = 0; cyc = 0; acc_cnt = 0;
        watch_ov = 1'b0; saw_ov = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (3) step();
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_sum", {32'b0, sum}, 64'd0);
        check("rst_co_ov", {62'b0, cout, ovf}, 64'd0);
        rst_n = 1'b1;
        step();

        // Basic add with latency.
        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0, s, c, o, lat);
        check("basic_sum", {32'b0, s}, 64'h0000_0100);
        check("basic_cout", {63'b0, c}, 64'd0);
        check("basic_ovf", {63'b0, o}, 64'd0);
        check("basic_latency", lat, 5);
        check("idle_after_consume", {62'b0, in_ready, out_valid}, 64'b10);

        // Full carry ripple.
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, s, c, o, lat);
        check("ripple_sum", {32'b0, s}, 64'h0);
        check("ripple_cout", {63'b0, c}, 64'd1);
        check("ripple_ovf", {63'b0, o}, 64'd0);

        // Signed overflow.
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, s, c, o, lat);
        check("ovf_sum", {32'b0, s}, 64'h8000_0000);
        check("ovf_cout", {63'b0, c}, 64'd0);
        check("ovf_ovf", {63'b0, o}, 64'd1);

        // Negative + negative overflow under backpressure.
        run_op(32'h8000_0000, 32'h8000_0001, 1'b0, 10, s, c, o, lat);
        check("bp_res_sum", {32'b0, s}, 64'h0000_0001);
        check("bp_res_cout", {63'b0, c}, 64'd1);
        check("bp_res_ovf", {63'b0, o}, 64'd1);
        check("bp_idle", {62'b0, in_ready, out_valid}, 64'b10);

        // Reset mid-RUN at cnt==2.
        a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0; in_valid = 1'b1;
        step();                          // accept, cnt=0
        in_valid = 1'b0;
        watch_ov = 1'b1;
        step();                          // cnt=1
        step();                          // cnt=2
        #2 rst_n = 1'b0;
        #1;
        check("rstrun_in_ready", {63'b0, in_ready}, 64'd1);
        check("rstrun_out_valid", {63'b0, out_valid}, 64'd0);
        check("rstrun_sum", {32'b0, sum}, 64'd0);
        check("rstrun_co_ov", {62'b0, cout, ovf}, 64'd0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (8) step();
        check("rstrun_no_ov_pulse", {63'b0, saw_ov}, 64'd0);
        watch_ov = 1'b0;
        run_op(32'd5, 32'd7, 1'b0, 0, s, c, o, lat);
        check("post_rst_sum", {32'b0, s}, 64'd12);

        // Back-to-back with out_ready tied high.
        step();
        acc_cnt = 0;
        out_ready = 1'b1;
        a = 32'h0000_0010; b = 32'h0000_0020; cin = 1'b0; in_valid = 1'b1;
        n = 0;
        while (acc_cnt < 1 && n < 50) begin step(); n++; end
        a = 32'h0000_0100; b = 32'h0000_0200;
        while (acc_cnt < 2 && n < 50) begin step(); n++; end
        in_valid = 1'b0;
        check("b2b_accepts", acc_cnt, 2);
        check("b2b_spacing", acc_cyc[1] - acc_cyc[0], NB + 2);
        n = 0;
        while (!out_valid && n < 50) begin step(); n++; end
        check("b2b_second_sum", {32'b0, sum}, 64'h0000_0300);
        step();
        out_ready = 1'b0;
        step();

        // Random operations against a full-width reference.
        for (int it = 0; it < 1000; it++) begin
            ra = $urandom; rb = $urandom; rc = $urandom_range(0, 1);
            ref_full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            run_op(ra, rb, rc, 0, s, c, o, lat);
            check("rand_sum", {32'b0, s}, {32'b0, ref_full[W-1:0]});
            check("rand_cout", {63'b0, c}, {63'b0, ref_full[W]});
            check("rand_ovf", {63'b0, o},
                  {63'b0, (ra[W-1] == rb[W-1]) && (ref_full[W-1] != ra[W-1])});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-byte serial add sequencer that sits directly upstream of `carry_select_adder_8bit`. It accepts a wide operand pair through a valid/ready handshake and feeds the 8-bit adder one byte per cycle, LSB first. It registers the adder's `Cout` as the next byte's `Cin` and collects the sum bytes. It returns the wide sum, carry-out and signed overflow through a second valid/ready handshake.

## Interface
- `NBYTES`, 4: operand width in bytes; legal range 2..16.
- `CNT_W`, $clog2(NBYTES): byte-counter width, derived, not overridden.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  block can accept an operand pair.
- `a`  in  8*NBYTES  operand A.
- `b`  in  8*NBYTES  operand B.
- `cin`  in  1  carry into byte 0.
- `out_valid`  out  1  result held and valid.
- `out_ready`  in  1  consumer takes the result.
- `sum`  out  8*NBYTES  result, a+b+cin modulo 2^(8*NBYTES).
- `cout`  out  1  carry out of the top byte.
- `ovf`  out  1  two's-complement overflow of the full-width add.

## Operation
- The block runs a three-state FSM: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, register `a`, `b` and `cin` into the operand registers.
  - Clear the byte counter to 0 and go to RUN.
- RUN:
  - Each cycle, drive byte[cnt] of A and B plus the carry register into the single adder instance.
  - Write the adder `S` into sum byte[cnt] and the adder `Cout` into the carry register.
  - Increment cnt.
  - When cnt==NBYTES-1, go to DONE after this write.
- DONE:
  - `out_valid`=1.
  - `sum`, `cout` and `ovf` are stable.
  - On `out_ready`, go to IDLE.
- `in_ready` is 1 only in IDLE. There is no accept in DONE, even when `out_ready` is high.
- `cout` is the carry register after the final byte.
- `ovf` = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), using the registered operands.
- Inputs `a`, `b` and `cin` may change freely after acceptance, because only the registered copies are used.
- Reset values:
  - State is IDLE, cnt is 0, the carry register is 0.
  - Operand and sum registers are 0.
  - Outputs: `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0.
- Reset mid-RUN or mid-DONE abandons the operation immediately. No partial result is ever presented.
- `out_ready` is ignored outside DONE. `in_valid` is ignored outside IDLE.
- Stalls: `out_valid` stays asserted with unchanged data for any number of cycles until `out_ready`.

## Timing
- The accept edge is cycle 0. RUN occupies edges 1..NBYTES.
- `out_valid` rises after edge NBYTES, so it is first visible in the cycle following the NBYTES-th RUN edge. Latency is NBYTES+1 cycles from accept to `out_valid`.
- The result is consumed on the edge where `out_valid`&&`out_ready`. `in_ready` rises the cycle after that.
- Throughput is one operation per NBYTES+2 cycles with `out_ready` tied high.
- The path from the carry register through the adder to the carry register is the only combinational datapath. The adder is not pipelined.

## Structure
- Shared package `wide_add_pkg` holds:
  - the state enum `wadd_state_t` {IDLE, RUN, DONE};
  - the localparam `WADD_MAX_BYTES`=16, used in the legal-range elaboration check.
- There is exactly one sub-module: the existing `carry_select_adder_8bit`, instantiated once as the byte datapath.
- Everything else is flat in `wide_add_sequencer`: FSM, counter, carry register, operand and sum shift/index registers.

## Test plan
All scenarios use NBYTES=4.
- **Basic add:** a=0x0000_00FF, b=0x0000_0001, cin=0.
  - Required: sum=0x0000_0100, cout=0, ovf=0.
  - Required: `out_valid` first high exactly 5 cycles after the accept edge.
- **Full carry ripple:** a=0xFFFF_FFFF, b=0x0000_0000, cin=1.
  - Required: sum=0x0000_0000, cout=1, ovf=0.
- **Signed overflow:** a=0x7FFF_FFFF, b=0x0000_0001, cin=0.
  - Required: sum=0x8000_0000, cout=0, ovf=1.
- **Backpressure:** with `out_ready`=0 for 10 cycles after `out_valid`:
  - Required: `sum`/`cout`/`ovf` unchanged and `in_ready`=0 throughout.
  - Required: `in_valid` pulses during this window are not accepted.
- **Reset mid-RUN:** assert `rst_n`=0 at cnt==2, then release.
  - Required: all outputs return to their reset values asynchronously and `out_valid` never pulses.
  - Required: the next operation (a=5, b=7) yields sum=12.
- **Back-to-back:** two operations with `out_ready` tied high.
  - Required: second accept exactly NBYTES+2 cycles after the first.
  - Required: random a/b/cin results match a reference model over 1000 iterations.
